// File: rtl/zap_shift_resolve_stage_pkg.sv
// Shared definitions for the shift/resolve stage: shift opcodes and operand descriptor layout.
package zap_shift_resolve_stage_pkg;

   typedef enum logic [2:0] {
      OpLsl  = 3'd0,
      OpLsr  = 3'd1,
      OpAsr  = 3'd2,
      OpRor  = 3'd3,
      OpRrx  = 3'd4,
      OpNone = 3'd5
   } shift_op_e;

   // Width of the shift-amount field taken from operand 1.
   localparam int unsigned AMT_FIELD_W = 8;

   // IMMED_EN sits directly above the value/index field of each operand descriptor.
   function automatic int unsigned immed_en_bit(input int unsigned data_w);
      return data_w;
   endfunction

endpackage

// File: rtl/zap_shift_step.sv
// Combinational bounded shifter: applies one step of at most SHIFT_STEP bits and produces carry-out.
module zap_shift_step
   import zap_shift_resolve_stage_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned SHIFT_STEP = 8,
   localparam int unsigned STEP_W    = $clog2(SHIFT_STEP + 1)
) (
   input  logic [DATA_W-1:0] value_i,
   input  logic              carry_i,
   input  logic [2:0]        op_i,
   input  logic [STEP_W-1:0] amt_i,
   output logic [DATA_W-1:0] value_o,
   output logic              carry_o
);

   logic [DATA_W:0]   lsl_w;
   logic [DATA_W:0]   lsr_w;
   logic [DATA_W:0]   asr_w;
   logic [DATA_W-1:0] ror_v;

   always_comb begin
      // One extra bit beside the value catches the last bit shifted out.
      lsl_w = {1'b0, value_i} << amt_i;
      lsr_w = {value_i, 1'b0} >> amt_i;
      asr_w = $signed({value_i, 1'b0}) >>> amt_i;
      ror_v = DATA_W'({value_i, value_i} >> amt_i);

      value_o = value_i;
      carry_o = carry_i;
      if (op_i == OpRrx) begin
         value_o = {carry_i, value_i[DATA_W-1:1]};
         carry_o = value_i[0];
      end else if (amt_i != '0) begin
         case (op_i)
            OpLsl: begin
               value_o = lsl_w[DATA_W-1:0];
               carry_o = lsl_w[DATA_W];
            end
            OpLsr: begin
               value_o = lsr_w[DATA_W:1];
               carry_o = lsr_w[0];
            end
            OpAsr: begin
               value_o = asr_w[DATA_W:1];
               carry_o = asr_w[0];
            end
            OpRor: begin
               value_o = ror_v;
               carry_o = ror_v[DATA_W-1];
            end
            default: begin
               value_o = value_i;
               carry_o = carry_i;
            end
         endcase
      end
   end

endmodule

// File: rtl/zap_shift_resolve_stage.sv
// Shift stage between issue and ALU: resolves operands against forwarding, then shifts operand 0
// iteratively SHIFT_STEP bits per cycle, stalling upstream while a long shift is in flight.
module zap_shift_resolve_stage
   import zap_shift_resolve_stage_pkg::*;
#(
   parameter int unsigned PHY_REGS   = 46,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_SRC    = 3,
   parameter int unsigned NUM_FWD    = 2,
   parameter int unsigned SHIFT_STEP = 8,
   localparam int unsigned IDX_W     = $clog2(PHY_REGS)
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_clear_hi,
   input  logic                          i_stall,
   input  logic                          i_clear_lo,
   input  logic                          i_valid,
   input  logic [IDX_W-1:0]              i_dest_index,
   input  logic [2:0]                    i_shift_op,
   input  logic                          i_carry_in,
   input  logic [NUM_SRC*(DATA_W+1)-1:0] i_src_index,
   input  logic [NUM_SRC*DATA_W-1:0]     i_src_value,
   input  logic [NUM_FWD-1:0]            i_fwd_valid,
   input  logic [NUM_FWD*IDX_W-1:0]      i_fwd_index,
   input  logic [NUM_FWD*DATA_W-1:0]     i_fwd_value,
   output logic                          o_valid,
   output logic [IDX_W-1:0]              o_dest_index,
   output logic [NUM_SRC*DATA_W-1:0]     o_src_value,
   output logic [DATA_W-1:0]             o_shifted,
   output logic                          o_shift_carry,
   output logic                          o_stall
);

   localparam int unsigned SRC_W   = DATA_W + 1;
   localparam int unsigned AMT_W   = $clog2(DATA_W + 2);
   localparam int unsigned STEP_W  = $clog2(SHIFT_STEP + 1);
   localparam int unsigned IMMEDEN = immed_en_bit(DATA_W);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e                     state_q, state_d;
   logic [DATA_W-1:0]          work_q, work_d;
   logic                       wcarry_q, wcarry_d;
   logic [AMT_W-1:0]           rem_q, rem_d;
   logic [2:0]                 op_q, op_d;
   logic [IDX_W-1:0]           hdest_q, hdest_d;
   logic [NUM_SRC*DATA_W-1:0]  hsrc_q, hsrc_d;
   logic                       valid_q, valid_d;
   logic [IDX_W-1:0]           dest_q, dest_d;
   logic [NUM_SRC*DATA_W-1:0]  src_q, src_d;
   logic [DATA_W-1:0]          shifted_q, shifted_d;
   logic                       scarry_q, scarry_d;

   logic [SRC_W-1:0]           src_field;
   logic [NUM_SRC*DATA_W-1:0]  src_res;
   logic [AMT_FIELD_W-1:0]     amt;
   logic [AMT_FIELD_W-1:0]     ror_m;
   logic [AMT_W-1:0]           amt_eff;
   logic                       long_acc;
   logic                       rem_long;
   logic                       flush;
   logic [STEP_W-1:0]          first_amt;
   logic [STEP_W-1:0]          rem_amt;
   logic                       shifting;
   logic [DATA_W-1:0]          step_val_i;
   logic                       step_c_i;
   logic [2:0]                 step_op_i;
   logic [STEP_W-1:0]          step_amt_i;
   logic [DATA_W-1:0]          step_val_o;
   logic                       step_c_o;

   // Operand resolution: immediate, else lowest-numbered matching channel, else register read.
   always_comb begin
      src_res   = '0;
      src_field = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         src_field = i_src_index[s*SRC_W +: SRC_W];
         src_res[s*DATA_W +: DATA_W] = i_src_value[s*DATA_W +: DATA_W];
         for (int f = NUM_FWD - 1; f >= 0; f--) begin
            if (i_fwd_valid[f] && (i_fwd_index[f*IDX_W +: IDX_W] == src_field[IDX_W-1:0])) begin
               src_res[s*DATA_W +: DATA_W] = i_fwd_value[f*DATA_W +: DATA_W];
            end
         end
         if (src_field[IMMEDEN]) begin
            src_res[s*DATA_W +: DATA_W] = src_field[DATA_W-1:0];
         end
      end
   end

   always_comb begin
      amt     = src_res[DATA_W +: AMT_FIELD_W];
      ror_m   = amt % AMT_FIELD_W'(DATA_W);
      amt_eff = '0;
      case (i_shift_op)
         OpLsl, OpLsr: amt_eff = (amt > AMT_FIELD_W'(DATA_W + 1)) ? AMT_W'(DATA_W + 1) : AMT_W'(amt);
         OpAsr:        amt_eff = (amt > AMT_FIELD_W'(DATA_W)) ? AMT_W'(DATA_W) : AMT_W'(amt);
         OpRor: begin
            // Non-zero multiples of the width rotate by a full word (carry = bit 31).
            if (amt != '0) amt_eff = (ror_m == '0) ? AMT_W'(DATA_W) : AMT_W'(ror_m);
         end
         default:      amt_eff = '0;
      endcase
      long_acc  = amt_eff > AMT_W'(SHIFT_STEP);
      rem_long  = rem_q > AMT_W'(SHIFT_STEP);
      first_amt = long_acc ? STEP_W'(SHIFT_STEP) : STEP_W'(amt_eff);
      rem_amt   = rem_long ? STEP_W'(SHIFT_STEP) : STEP_W'(rem_q);
      flush     = i_reset | i_clear_hi | (i_clear_lo & ~i_stall);
   end

   // One shifter serves both the acceptance step and every iterative step.
   always_comb begin
      shifting   = (state_q == StShift);
      step_val_i = shifting ? work_q   : src_res[DATA_W-1:0];
      step_c_i   = shifting ? wcarry_q : i_carry_in;
      step_op_i  = shifting ? op_q     : i_shift_op;
      step_amt_i = shifting ? rem_amt  : first_amt;
   end

   zap_shift_step #(
      .DATA_W     (DATA_W),
      .SHIFT_STEP (SHIFT_STEP)
   ) u_step (
      .value_i (step_val_i),
      .carry_i (step_c_i),
      .op_i    (step_op_i),
      .amt_i   (step_amt_i),
      .value_o (step_val_o),
      .carry_o (step_c_o)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= StIdle;
         work_q    <= '0;
         wcarry_q  <= 1'b0;
         rem_q     <= '0;
         op_q      <= '0;
         hdest_q   <= '0;
         hsrc_q    <= '0;
         valid_q   <= 1'b0;
         dest_q    <= '0;
         src_q     <= '0;
         shifted_q <= '0;
         scarry_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         wcarry_q  <= wcarry_d;
         rem_q     <= rem_d;
         op_q      <= op_d;
         hdest_q   <= hdest_d;
         hsrc_q    <= hsrc_d;
         valid_q   <= valid_d;
         dest_q    <= dest_d;
         src_q     <= src_d;
         shifted_q <= shifted_d;
         scarry_q  <= scarry_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      wcarry_d  = wcarry_q;
      rem_d     = rem_q;
      op_d      = op_q;
      hdest_d   = hdest_q;
      hsrc_d    = hsrc_q;
      valid_d   = valid_q;
      dest_d    = dest_q;
      src_d     = src_q;
      shifted_d = shifted_q;
      scarry_d  = scarry_q;
      if (i_clear_hi || (!i_stall && i_clear_lo)) begin
         state_d   = StIdle;
         work_d    = '0;
         wcarry_d  = 1'b0;
         rem_d     = '0;
         op_d      = '0;
         hdest_d   = '0;
         hsrc_d    = '0;
         valid_d   = 1'b0;
         dest_d    = '0;
         src_d     = '0;
         shifted_d = '0;
         scarry_d  = 1'b0;
      end else if (!i_stall) begin
         case (state_q)
            StIdle: begin
               valid_d   = 1'b0;
               dest_d    = '0;
               src_d     = '0;
               shifted_d = '0;
               scarry_d  = 1'b0;
               if (i_valid && long_acc) begin
                  work_d   = step_val_o;
                  wcarry_d = step_c_o;
                  rem_d    = amt_eff - AMT_W'(SHIFT_STEP);
                  op_d     = i_shift_op;
                  hdest_d  = i_dest_index;
                  hsrc_d   = src_res;
                  state_d  = StShift;
               end else if (i_valid) begin
                  valid_d   = 1'b1;
                  dest_d    = i_dest_index;
                  src_d     = src_res;
                  shifted_d = step_val_o;
                  scarry_d  = step_c_o;
               end
            end
            StShift: begin
               work_d   = step_val_o;
               wcarry_d = step_c_o;
               if (rem_long) begin
                  rem_d   = rem_q - AMT_W'(SHIFT_STEP);
                  valid_d = 1'b0;
               end else begin
                  rem_d     = '0;
                  valid_d   = 1'b1;
                  dest_d    = hdest_q;
                  src_d     = hsrc_q;
                  shifted_d = step_val_o;
                  scarry_d  = step_c_o;
                  state_d   = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Upstream hold request; a flushed instruction never holds the pipe.
   always_comb begin
      o_stall = 1'b0;
      if (!flush) begin
         case (state_q)
            StIdle:  o_stall = i_valid && long_acc;
            StShift: o_stall = rem_long;
            default: o_stall = 1'b0;
         endcase
      end
   end

   assign o_valid       = valid_q;
   assign o_dest_index  = dest_q;
   assign o_src_value   = src_q;
   assign o_shifted     = shifted_q;
   assign o_shift_carry = scarry_q;

endmodule

// File: tb/tb_zap_shift_resolve_stage.sv
// Scoreboard bench: a driver issues directed instructions and queues expected results; a monitor
// pops and compares whenever the stage presents a fresh result.
module tb_zap_shift_resolve_stage;

   logic        i_clk = 1'b0;
   logic        i_reset, i_clear_hi, i_stall, i_clear_lo, i_valid;
   logic [5:0]  i_dest_index;
   logic [2:0]  i_shift_op;
   logic        i_carry_in;
   logic [98:0] i_src_index;
   logic [95:0] i_src_value;
   logic [1:0]  i_fwd_valid;
   logic [11:0] i_fwd_index;
   logic [63:0] i_fwd_value;
   logic        o_valid;
   logic [5:0]  o_dest_index;
   logic [95:0] o_src_value;
   logic [31:0] o_shifted;
   logic        o_shift_carry;
   logic        o_stall;

   typedef struct {
      logic [5:0]  dest;
      logic [31:0] s0;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [31:0] val;
      logic        c;
   } exp_t;

   exp_t        sb[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [5:0]  dest_ctr = 6'd1;
   logic [31:0] src_val0 = 32'h1111_1111;
   logic        edge_hold = 1'b0;

   zap_shift_resolve_stage dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_clear_hi    (i_clear_hi),
      .i_stall       (i_stall),
      .i_clear_lo    (i_clear_lo),
      .i_valid       (i_valid),
      .i_dest_index  (i_dest_index),
      .i_shift_op    (i_shift_op),
      .i_carry_in    (i_carry_in),
      .i_src_index   (i_src_index),
      .i_src_value   (i_src_value),
      .i_fwd_valid   (i_fwd_valid),
      .i_fwd_index   (i_fwd_index),
      .i_fwd_value   (i_fwd_value),
      .o_valid       (o_valid),
      .o_dest_index  (o_dest_index),
      .o_src_value   (o_src_value),
      .o_shifted     (o_shifted),
      .o_shift_carry (o_shift_carry),
      .o_stall       (o_stall)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // A held (stalled) result must not be consumed twice.
   always @(posedge i_clk) edge_hold = i_stall && !i_clear_hi && !i_reset;

   always @(negedge i_clk) begin
      if (!i_reset && o_valid && !edge_hold) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_valid: got o_valid=1 dest=%0d, want no result", o_dest_index);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mon_shifted", o_shifted, e.val);
            chk("mon_carry", o_shift_carry, e.c);
            chk("mon_dest", o_dest_index, e.dest);
            chk("mon_src0", o_src_value[31:0], e.s0);
            chk("mon_src1", o_src_value[63:32], e.s1);
            chk("mon_src2", o_src_value[95:64], e.s2);
         end
      end
   end

   task automatic setup(input logic [2:0] op, input logic [32:0] s0, input logic [7:0] amt,
                        input logic c);
      i_valid      = 1'b1;
      i_shift_op   = op;
      i_carry_in   = c;
      i_dest_index = dest_ctr;
      i_src_index  = {1'b0, 32'd40, 1'b1, 24'h0, amt, s0};
      i_src_value  = {32'hC0DE_0000 | {26'h0, dest_ctr}, 32'h2222_2222, src_val0};
   endtask

   task automatic send(input string name, input logic [2:0] op, input logic [32:0] s0,
                       input logic [7:0] amt, input logic c, input logic [31:0] exp_v,
                       input logic exp_c, input int exp_stalls, input int exp_cycles,
                       input int stall_cyc);
      exp_t e;
      int   cyc = 0;
      int   stalls = 0;
      logic acc = 1'b0;
      logic accepted = 1'b0;
      setup(op, s0, amt, c);
      e.dest = dest_ctr;
      if (s0[32]) e.s0 = s0[31:0];
      else if (i_fwd_valid[0] && i_fwd_index[5:0] == s0[5:0]) e.s0 = i_fwd_value[31:0];
      else if (i_fwd_valid[1] && i_fwd_index[11:6] == s0[5:0]) e.s0 = i_fwd_value[63:32];
      else e.s0 = src_val0;
      e.s1  = {24'h0, amt};
      e.s2  = 32'hC0DE_0000 | {26'h0, dest_ctr};
      e.val = exp_v;
      e.c   = exp_c;
      sb.push_back(e);
      while (!accepted && cyc < 40) begin
         cyc++;
         i_stall = (cyc == stall_cyc);
         @(negedge i_clk);
         if (o_stall) stalls++;
         acc = !o_stall && !i_stall;
         @(posedge i_clk);
         #1;
         accepted = acc;
      end
      i_valid  = 1'b0;
      i_stall  = 1'b0;
      dest_ctr = (dest_ctr == 6'd45) ? 6'd0 : dest_ctr + 6'd1;
      chk({name, "_cycles"}, cyc, exp_cycles);
      chk({name, "_stalls"}, stalls, exp_stalls);
      chk({name, "_latency"}, o_valid, 1'b1);
   endtask

   // Start an LSL by 32, then flush it in the first SHIFT cycle.
   task automatic abort_run(input string name, input logic hi);
      setup(3'd0, {1'b1, 32'h0000_FFFF}, 8'd32, 1'b0);
      @(negedge i_clk);
      chk({name, "_stall_accept"}, o_stall, 1'b1);
      @(posedge i_clk);
      #1;
      if (hi) begin
         i_clear_hi = 1'b1;
         i_stall    = 1'b1;
      end else begin
         i_clear_lo = 1'b1;
      end
      @(posedge i_clk);
      #1;
      i_clear_hi = 1'b0;
      i_clear_lo = 1'b0;
      i_stall    = 1'b0;
      i_valid    = 1'b0;
      chk({name, "_valid"}, o_valid, 1'b0);
      chk({name, "_stall"}, o_stall, 1'b0);
      chk({name, "_shifted"}, o_shifted, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end

   initial begin
      i_reset = 1'b1;
      i_clear_hi = 1'b0;
      i_clear_lo = 1'b0;
      i_stall = 1'b0;
      i_valid = 1'b0;
      i_dest_index = '0;
      i_shift_op = '0;
      i_carry_in = 1'b0;
      i_src_index = '0;
      i_src_value = '0;
      i_fwd_valid = '0;
      i_fwd_index = '0;
      i_fwd_value = '0;
      repeat (3) @(posedge i_clk);
      #1;
      chk("reset_valid", o_valid, 1'b0);
      chk("reset_stall", o_stall, 1'b0);
      chk("reset_shifted", o_shifted, 32'h0);
      chk("reset_dest", o_dest_index, 6'h0);
      chk("reset_carry", o_shift_carry, 1'b0);
      i_reset = 1'b0;

      //   name        op    src0                    amt     C     result          Cout stl cyc stallcyc
      send("lsl4",     3'd0, {1'b1, 32'h0000_00F1}, 8'd4,   1'b1, 32'h0000_0F10, 1'b0, 0, 1, 0);
      send("lsr33",    3'd1, {1'b1, 32'h8000_0001}, 8'd33,  1'b1, 32'h0000_0000, 1'b0, 4, 5, 0);
      send("asr20",    3'd2, {1'b1, 32'h8000_0000}, 8'd20,  1'b1, 32'hFFFF_F800, 1'b0, 2, 3, 0);
      send("asr20_stl",3'd2, {1'b1, 32'h8000_0000}, 8'd20,  1'b1, 32'hFFFF_F800, 1'b0, 3, 4, 2);
      send("ror0",     3'd3, {1'b1, 32'h1234_5678}, 8'd0,   1'b1, 32'h1234_5678, 1'b1, 0, 1, 0);
      send("rrx",      3'd4, {1'b1, 32'h0000_0003}, 8'd5,   1'b1, 32'h8000_0001, 1'b1, 0, 1, 0);
      send("ror36",    3'd3, {1'b1, 32'h0000_00F8}, 8'd36,  1'b0, 32'h8000_000F, 1'b1, 0, 1, 0);
      send("ror32",    3'd3, {1'b1, 32'h8000_0001}, 8'd32,  1'b0, 32'h8000_0001, 1'b1, 3, 4, 0);
      send("lsl32",    3'd0, {1'b1, 32'h0000_0003}, 8'd32,  1'b0, 32'h0000_0000, 1'b1, 3, 4, 0);
      send("asr200",   3'd2, {1'b1, 32'h8000_0000}, 8'd200, 1'b0, 32'hFFFF_FFFF, 1'b1, 3, 4, 0);
      send("lsr12",    3'd1, {1'b1, 32'hF000_0800}, 8'd12,  1'b0, 32'h000F_0000, 1'b1, 1, 2, 0);
      send("lsl9",     3'd0, {1'b1, 32'h0080_0001}, 8'd9,   1'b0, 32'h0000_0200, 1'b1, 1, 2, 0);
      send("lsl0",     3'd0, {1'b1, 32'h0000_0005}, 8'd0,   1'b1, 32'h0000_0005, 1'b1, 0, 1, 0);

      i_fwd_valid = 2'b11;
      i_fwd_index = {6'd5, 6'd5};
      i_fwd_value = {32'h5555_5555, 32'hAAAA_AAAA};
      send("fwd_ch0",  3'd5, {1'b0, 32'd5},          8'd0,   1'b0, 32'hAAAA_AAAA, 1'b0, 0, 1, 0);
      send("fwd_imm",  3'd5, {1'b1, 32'd7},          8'd0,   1'b0, 32'h0000_0007, 1'b0, 0, 1, 0);
      i_fwd_valid = 2'b10;
      send("fwd_ch1",  3'd5, {1'b0, 32'd5},          8'd0,   1'b1, 32'h5555_5555, 1'b1, 0, 1, 0);
      send("fwd_miss", 3'd5, {1'b0, 32'd6},          8'd0,   1'b0, 32'h1111_1111, 1'b0, 0, 1, 0);
      i_fwd_valid = 2'b00;

      abort_run("abort_lo", 1'b0);
      send("after_lo", 3'd0, {1'b1, 32'h0000_0003}, 8'd1,   1'b0, 32'h0000_0006, 1'b0, 0, 1, 0);
      abort_run("abort_hi", 1'b1);
      send("after_hi", 3'd1, {1'b1, 32'h0000_0100}, 8'd16,  1'b0, 32'h0000_0000, 1'b0, 1, 2, 0);

      repeat (3) @(posedge i_clk);
      #1;
      chk("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
